// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit write engine: runs the power-up init and configuration on its own,
// then turns each accepted byte into two E-strobed nibble writes followed by a settle wait.
module lcd_nibble_writer #(
  parameter int P_POWERUP    = 750000,
  parameter int P_WAIT_4MS   = 205000,
  parameter int P_WAIT_100US = 5000,
  parameter int P_WAIT_40US  = 2000,
  parameter int P_WAIT_CLEAR = 82000,
  parameter int P_E_SETUP    = 2,
  parameter int P_E_PULSE    = 12,
  parameter int P_NIBBLE_GAP = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iWrite,
  output logic       oReady,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data,
  output logic [3:0] oDbgState
);

  typedef enum logic [3:0] {
    PWR_WAIT  = 4'd0,
    INIT_NIB  = 4'd1,
    INIT_WAIT = 4'd2,
    CFG_BYTE  = 4'd3,
    IDLE      = 4'd4,
    NIB_SETUP = 4'd5,
    NIB_PULSE = 4'd6,
    NIB_GAP   = 4'd7,
    POST_WAIT = 4'd8
  } state_e;

  // Every state lasts N cycles: the counter is loaded with N-1 on entry and the
  // state is left on the cycle it reads zero.
  localparam logic [19:0] C_POWERUP  = 20'(P_POWERUP - 1);
  localparam logic [19:0] C_4MS      = 20'(P_WAIT_4MS - 1);
  localparam logic [19:0] C_100US    = 20'(P_WAIT_100US - 1);
  localparam logic [19:0] C_40US     = 20'(P_WAIT_40US - 1);
  localparam logic [19:0] C_CLEAR    = 20'(P_WAIT_CLEAR - 1);
  localparam logic [19:0] C_SETUP    = 20'(P_E_SETUP - 1);
  localparam logic [19:0] C_PULSE    = 20'(P_E_PULSE - 1);
  localparam logic [19:0] C_GAP      = 20'(P_NIBBLE_GAP - 1);
  localparam logic [19:0] C_INIT_NIB = 20'(P_E_SETUP + P_E_PULSE + P_NIBBLE_GAP - 1);
  localparam logic [19:0] C_E_LO     = 20'(P_NIBBLE_GAP);
  localparam logic [19:0] C_E_HI     = 20'(P_E_PULSE + P_NIBBLE_GAP);

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        nib_lo_q, nib_lo_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic [2:0]  cfg_idx_q, cfg_idx_d;
  logic [3:0]  data_q, data_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        e_q, e_d;
  logic        ready_q, ready_d;
  logic [7:0]  cfg_byte;

  always_comb begin
    case (cfg_idx_q)
      3'd0:    cfg_byte = 8'h28;
      3'd1:    cfg_byte = 8'h06;
      3'd2:    cfg_byte = 8'h0C;
      3'd3:    cfg_byte = 8'h01;
      default: cfg_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != 20'd0) ? cnt_q - 20'd1 : cnt_q;
    byte_d     = byte_q;
    rs_d       = rs_q;
    nib_lo_d   = nib_lo_q;
    init_idx_d = init_idx_q;
    cfg_idx_d  = cfg_idx_q;
    data_d     = data_q;
    lcd_rs_d   = lcd_rs_q;
    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == 20'd0) begin
          state_d  = INIT_NIB;
          cnt_d    = C_INIT_NIB;
          data_d   = 4'h3;
          lcd_rs_d = 1'b0;
        end
      end
      INIT_NIB: begin
        if (cnt_q == 20'd0) begin
          state_d = INIT_WAIT;
          case (init_idx_q)
            2'd0:    cnt_d = C_4MS;
            2'd1:    cnt_d = C_100US;
            default: cnt_d = C_40US;
          endcase
        end
      end
      INIT_WAIT: begin
        if (cnt_q == 20'd0) begin
          init_idx_d = init_idx_q + 2'd1;
          if (init_idx_q == 2'd3) begin
            state_d = CFG_BYTE;
          end else begin
            state_d = INIT_NIB;
            cnt_d   = C_INIT_NIB;
            data_d  = (init_idx_q == 2'd2) ? 4'h2 : 4'h3;
          end
        end
      end
      CFG_BYTE: begin
        byte_d    = cfg_byte;
        rs_d      = 1'b0;
        cfg_idx_d = cfg_idx_q + 3'd1;
        state_d   = NIB_SETUP;
        cnt_d     = C_SETUP;
        nib_lo_d  = 1'b0;
        data_d    = cfg_byte[7:4];
        lcd_rs_d  = 1'b0;
      end
      IDLE: begin
        if (iWrite) begin
          byte_d   = iData;
          rs_d     = iRS;
          state_d  = NIB_SETUP;
          cnt_d    = C_SETUP;
          nib_lo_d = 1'b0;
          data_d   = iData[7:4];
          lcd_rs_d = iRS;
        end
      end
      NIB_SETUP: begin
        if (cnt_q == 20'd0) begin
          state_d = NIB_PULSE;
          cnt_d   = C_PULSE;
        end
      end
      NIB_PULSE: begin
        if (cnt_q == 20'd0) begin
          state_d = NIB_GAP;
          cnt_d   = C_GAP;
        end
      end
      NIB_GAP: begin
        if (cnt_q == 20'd0) begin
          if (!nib_lo_q) begin
            state_d  = NIB_SETUP;
            cnt_d    = C_SETUP;
            nib_lo_d = 1'b1;
            data_d   = byte_q[3:0];
          end else begin
            // Clear display / return home need the long settle time.
            state_d = POST_WAIT;
            cnt_d   = (!rs_q && byte_q <= 8'h03) ? C_CLEAR : C_40US;
          end
        end
      end
      POST_WAIT: begin
        if (cnt_q == 20'd0) begin
          state_d = (cfg_idx_q < 3'd4) ? CFG_BYTE : IDLE;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  // E and ready are registered from the next state so they line up with the state change.
  always_comb begin
    ready_d = (state_d == IDLE);
    e_d     = (state_d == NIB_PULSE) ||
              ((state_d == INIT_NIB) && (cnt_d >= C_E_LO) && (cnt_d < C_E_HI));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= PWR_WAIT;
      cnt_q      <= C_POWERUP;
      byte_q     <= 8'h00;
      rs_q       <= 1'b0;
      nib_lo_q   <= 1'b0;
      init_idx_q <= 2'd0;
      cfg_idx_q  <= 3'd0;
      data_q     <= 4'h0;
      lcd_rs_q   <= 1'b0;
      e_q        <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      rs_q       <= rs_d;
      nib_lo_q   <= nib_lo_d;
      init_idx_q <= init_idx_d;
      cfg_idx_q  <= cfg_idx_d;
      data_q     <= data_d;
      lcd_rs_q   <= lcd_rs_d;
      e_q        <= e_d;
      ready_q    <= ready_d;
    end
  end

  assign oReady    = ready_q;
  assign oLCD_E    = e_q;
  assign oLCD_RS   = lcd_rs_q;
  assign oLCD_RW   = 1'b0;
  assign oLCD_Data = data_q;
  assign oDbgState = state_q;

endmodule
